// File: rtl/mux_scan_if.sv
// mux_scan_if
// Bundles the scan-sequencer signals shared between the sequencer and its
// environment (the structural mux plus the result consumer).
//
// Signals:
//   start         scan request from the consumer
//   mux_out       current output of the 7-input mux
//   address0..2   mux select bits, address0 is the LSB
//   busy          scan in progress
//   result        captured 7-bit word, bit i = mux_out sampled at select i
//   result_valid  result holds a completed scan
//   result_ack    consumer acknowledge
//
// Handshake: result_valid/result_ack form a valid/ready pair. Once
// result_valid is high, result and result_valid stay stable until an edge
// that sees result_ack=1; that edge retires the word. result_ack has no
// effect while result_valid is low. start is only looked at while the
// sequencer is idle (busy=0, result_valid=0).
//
// Modports:
//   master  the sequencer (drives select, status and result)
//   slave   the environment (drives start, mux_out and result_ack)

interface mux_scan_if;
  logic       start;
  logic       mux_out;
  logic       address0;
  logic       address1;
  logic       address2;
  logic       busy;
  logic [6:0] result;
  logic       result_valid;
  logic       result_ack;

  modport master (
    input  start,
    input  mux_out,
    input  result_ack,
    output address0,
    output address1,
    output address2,
    output busy,
    output result,
    output result_valid
  );

  modport slave (
    output start,
    output mux_out,
    output result_ack,
    input  address0,
    input  address1,
    input  address2,
    input  busy,
    input  result,
    input  result_valid
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Drives the 3-bit select of a 7-input structural mux through 0..6, holds
// each select for SETTLE_CYCLES clocks so the mux gates settle, captures
// mux_out at the end of each hold, and presents the assembled 7-bit word
// with a valid/ack handshake.
//
// Parameters:
//   SETTLE_CYCLES  cycles each select is held before its sample (1..15)
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   bus        mux_scan_if master modport (start, mux_out, address0..2,
//              busy, result, result_valid, result_ack)
//   fsm_state  current FSM state (0=IDLE, 1=SCAN, 2=DONE) for observation
//
// Timing: the edge accepting start enters SCAN with select 0. The sample
// for select i is taken on the edge that ends its hold, which is also the
// edge that moves the select to i+1, so every select value is held exactly
// SETTLE_CYCLES cycles and result_valid rises 7*SETTLE_CYCLES edges after
// the accept edge. All outputs are registered.

module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  mux_scan_if.master  bus,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on which the current select's hold ends.
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'd6;

  state_t     state;
  logic [2:0] index;
  logic [3:0] settle_cnt;
  logic [2:0] address;
  logic       busy_q;
  logic       valid_q;
  logic [6:0] result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= 3'd0;
      settle_cnt <= 4'd0;
      address    <= 3'd0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SCAN;
            index      <= 3'd0;
            settle_cnt <= 4'd0;
            address    <= 3'd0;
            busy_q     <= 1'b1;
            result_q   <= 7'd0;
          end
        end

        SCAN: begin
          if (settle_cnt == LAST_CNT) begin
            result_q[index] <= bus.mux_out;
            settle_cnt      <= 4'd0;
            if (index == LAST_IDX) begin
              // Last sample: park the select at 0 rather than stepping to 7.
              state   <= DONE;
              index   <= 3'd0;
              address <= 3'd0;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              index   <= index + 3'd1;
              address <= index + 3'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        DONE: begin
          // start is deliberately not looked at here, even alongside ack:
          // a new scan always begins from IDLE.
          if (bus.result_ack) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          index      <= 3'd0;
          settle_cnt <= 4'd0;
          address    <= 3'd0;
          busy_q     <= 1'b0;
          valid_q    <= 1'b0;
          result_q   <= 7'd0;
        end
      endcase
    end
  end

  assign bus.address0     = address[0];
  assign bus.address1     = address[1];
  assign bus.address2     = address[2];
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign fsm_state        = state;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: one instance with SETTLE_CYCLES=3 and
// one with SETTLE_CYCLES=1, each driving a small behavioural 7-input mux.

module tb_mux_scan_sequencer;

  logic clk;
  logic reset;

  mux_scan_if bus3 ();
  mux_scan_if bus1 ();

  logic [1:0] state3;
  logic [1:0] state1;

  // Mux input patterns, bit 7 padded so a stray select of 7 reads 0.
  logic [7:0] in3;
  logic [7:0] in1;
  logic [2:0] addr3;
  logic [2:0] addr1;

  int n_tests;
  int n_fail;

  assign addr3 = {bus3.address2, bus3.address1, bus3.address0};
  assign addr1 = {bus1.address2, bus1.address1, bus1.address0};
  assign bus3.mux_out = in3[addr3];
  assign bus1.mux_out = in1[addr1];

  mux_scan_sequencer #(.SETTLE_CYCLES(3)) u_seq3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus3),
    .fsm_state (state3)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) u_seq1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .fsm_state (state1)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at the negedge right after the accept edge of the SETTLE=3 unit.
  task automatic run_scan3(input string tag, input logic [6:0] exp);
    for (int j = 0; j < 21; j++) begin
      check({tag, "_addr"}, 32'(addr3), 32'(j / 3));
      check({tag, "_busy"}, 32'(bus3.busy), 32'd1);
      check({tag, "_valid_lo"}, 32'(bus3.result_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid_hi"}, 32'(bus3.result_valid), 32'd1);
    check({tag, "_result"}, 32'(bus3.result), 32'(exp));
    check({tag, "_done_busy"}, 32'(bus3.busy), 32'd0);
    check({tag, "_done_addr"}, 32'(addr3), 32'd0);
    check({tag, "_done_state"}, 32'(state3), 32'd2);
  endtask

  task automatic run_scan1(input string tag, input logic [6:0] exp);
    for (int j = 0; j < 7; j++) begin
      check({tag, "_addr"}, 32'(addr1), 32'(j));
      check({tag, "_valid_lo"}, 32'(bus1.result_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid_hi"}, 32'(bus1.result_valid), 32'd1);
    check({tag, "_result"}, 32'(bus1.result), 32'(exp));
    check({tag, "_done_addr"}, 32'(addr1), 32'd0);
  endtask

  initial begin
    logic [6:0] held;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus3.start = 1'b0;
    bus3.result_ack = 1'b0;
    bus1.start = 1'b0;
    bus1.result_ack = 1'b0;
    in3 = 8'h00;
    in1 = 8'b0010_1010;

    // Reset state
    wait_cycles(2);
    check("rst_state3", 32'(state3), 32'd0);
    check("rst_busy3", 32'(bus3.busy), 32'd0);
    check("rst_valid3", 32'(bus3.result_valid), 32'd0);
    check("rst_result3", 32'(bus3.result), 32'd0);
    check("rst_addr3", 32'(addr3), 32'd0);
    check("rst_state1", 32'(state1), 32'd0);

    // Reset dominates start; first edge after reset may accept start.
    bus1.start = 1'b1;
    bus3.result_ack = 1'b1;
    @(negedge clk);
    check("rst_blocks_start", 32'(bus1.busy), 32'd0);
    check("rst_blocks_state", 32'(state1), 32'd0);
    reset = 1'b0;
    bus3.result_ack = 1'b0;
    @(negedge clk);
    check("first_edge_accept", 32'(bus1.busy), 32'd1);
    bus1.start = 1'b0;
    run_scan1("post_rst_s1", 7'b0101010);
    bus1.result_ack = 1'b1;
    @(negedge clk);
    bus1.result_ack = 1'b0;
    check("post_rst_s1_idle", 32'(state1), 32'd0);

    // Basic scan, SETTLE=3, inputs 1010011
    in3 = 8'b0101_0011;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    run_scan3("basic", 7'b1010011);

    // Handshake: result holds while ack is low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus3.result_valid), 32'd1);
      check("hold_result", 32'(bus3.result), 32'h53);
    end
    bus3.result_ack = 1'b1;
    @(negedge clk);
    bus3.result_ack = 1'b0;
    check("ack_idle_state", 32'(state3), 32'd0);
    check("ack_valid_lo", 32'(bus3.result_valid), 32'd0);
    // ack pulsed in IDLE does nothing
    bus3.result_ack = 1'b1;
    @(negedge clk);
    bus3.result_ack = 1'b0;
    check("idle_ack_state", 32'(state3), 32'd0);
    check("idle_ack_valid", 32'(bus3.result_valid), 32'd0);
    check("idle_ack_busy", 32'(bus3.busy), 32'd0);

    // Start held high for the whole scan and while valid
    in3 = 8'b0011_0101;
    bus3.start = 1'b1;
    @(negedge clk);
    run_scan3("held", 7'b0110101);
    held = bus3.result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_no_restart", 32'(state3), 32'd2);
      check("held_result", 32'(bus3.result), 32'h35);
    end
    // start together with ack in DONE: back to IDLE, no scan
    bus3.result_ack = 1'b1;
    @(negedge clk);
    bus3.result_ack = 1'b0;
    check("sim_idle_state", 32'(state3), 32'd0);
    check("sim_idle_busy", 32'(bus3.busy), 32'd0);
    check("sim_result_kept", 32'(bus3.result), 32'(held));
    // start still high: accepted on the following edge, result cleared
    in3 = 8'b0100_1100;
    @(negedge clk);
    bus3.start = 1'b0;
    check("sim_accept_busy", 32'(bus3.busy), 32'd1);
    check("sim_accept_clear", 32'(bus3.result), 32'd0);
    run_scan3("after_sim", 7'b1001100);
    bus3.result_ack = 1'b1;
    @(negedge clk);
    bus3.result_ack = 1'b0;

    // Reset mid-scan at index 4
    in3 = 8'b0111_1111;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    wait_cycles(12);
    check("mid_addr4", 32'(addr3), 32'd4);
    check("mid_partial", 32'(bus3.result), 32'h0f);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(bus3.busy), 32'd0);
    check("mid_rst_result", 32'(bus3.result), 32'd0);
    check("mid_rst_addr", 32'(addr3), 32'd0);
    check("mid_rst_state", 32'(state3), 32'd0);
    wait_cycles(12);
    check("mid_rst_no_valid", 32'(bus3.result_valid), 32'd0);
    in3 = 8'b0100_1110;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    run_scan3("fresh", 7'b1001110);
    bus3.result_ack = 1'b1;
    @(negedge clk);
    bus3.result_ack = 1'b0;

    // Minimum settle, SETTLE=1, inputs 0000001
    in1 = 8'b0000_0001;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    run_scan1("min_settle", 7'b0000001);
    bus1.result_ack = 1'b1;
    @(negedge clk);
    bus1.result_ack = 1'b0;
    check("min_settle_idle", 32'(state1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Select 7 must never appear on either unit.
  always @(negedge clk) begin
    if (!reset) begin
      if (addr3 == 3'd7) check("addr3_never7", 32'(addr3), 32'd0);
      if (addr1 == 3'd7) check("addr1_never7", 32'(addr1), 32'd0);
    end
  end

endmodule
